// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared constants for the multi-cycle MIPS control unit.
//   - FSM state codes (5-bit, also exported on the debug 'state' port)
//   - ALU_Control codes
//   - opcode / funct constants for the supported instruction subset
//   - datapath mux-select codes
package mcpu_pkg;

    typedef logic [4:0] state_t;

    // FSM state codes
    localparam logic [4:0] S_IF   = 5'd0;
    localparam logic [4:0] S_ID   = 5'd1;
    localparam logic [4:0] S_REX  = 5'd2;
    localparam logic [4:0] S_RWB  = 5'd3;
    localparam logic [4:0] S_IEX  = 5'd4;
    localparam logic [4:0] S_IWB  = 5'd5;
    localparam logic [4:0] S_MA   = 5'd6;
    localparam logic [4:0] S_MR   = 5'd7;
    localparam logic [4:0] S_MW   = 5'd8;
    localparam logic [4:0] S_LWB  = 5'd9;
    localparam logic [4:0] S_BEQ  = 5'd10;
    localparam logic [4:0] S_BNE  = 5'd11;
    localparam logic [4:0] S_J    = 5'd12;
    localparam logic [4:0] S_JR   = 5'd13;
    localparam logic [4:0] S_JAL  = 5'd14;
    localparam logic [4:0] S_JALR = 5'd15;
    localparam logic [4:0] S_LUI  = 5'd16;
    localparam logic [4:0] S_TRAP = 5'd17;

    // ALU_Control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes (IR[5:0]) for OP_RTYPE
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Mux-select codes
    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_RA   = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_LUI = 2'b10;
    localparam logic [1:0] M2R_PC  = 2'b11;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFS  = 2'b11;
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    // States that own the memory bus and may wait on MIO_ready
    function automatic logic is_mem_state(input logic [4:0] s);
        return (s == S_IF) || (s == S_MR) || (s == S_MW);
    endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// mcpu_alu_dec: combinational ALU-control decoder.
//   Fun        in  6  funct field for R-type ALU operations
//   OPcode     in  6  opcode for immediate ALU operations
//   r_alu_ctrl out 3  ALU_Control for the R-type funct
//   r_valid    out 1  Fun is a supported R-type ALU funct
//   i_alu_ctrl out 3  ALU_Control for the immediate opcode
//   i_valid    out 1  OPcode is a supported immediate ALU opcode
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    output logic [2:0] r_alu_ctrl,
    output logic       r_valid,
    output logic [2:0] i_alu_ctrl,
    output logic       i_valid
);

    // R-type funct -> ALU operation
    always_comb begin
        r_alu_ctrl = ALU_ADD;
        r_valid    = 1'b1;
        case (Fun)
            FN_ADD:  r_alu_ctrl = ALU_ADD;
            FN_SUB:  r_alu_ctrl = ALU_SUB;
            FN_AND:  r_alu_ctrl = ALU_AND;
            FN_OR:   r_alu_ctrl = ALU_OR;
            FN_XOR:  r_alu_ctrl = ALU_XOR;
            FN_NOR:  r_alu_ctrl = ALU_NOR;
            FN_SLT:  r_alu_ctrl = ALU_SLT;
            FN_SRL:  r_alu_ctrl = ALU_SRL;
            default: r_valid    = 1'b0;
        endcase
    end

    // Immediate opcode -> ALU operation
    always_comb begin
        i_alu_ctrl = ALU_ADD;
        i_valid    = 1'b1;
        case (OPcode)
            OP_ADDI: i_alu_ctrl = ALU_ADD;
            OP_ANDI: i_alu_ctrl = ALU_AND;
            OP_ORI:  i_alu_ctrl = ALU_OR;
            OP_XORI: i_alu_ctrl = ALU_XOR;
            OP_SLTI: i_alu_ctrl = ALU_SLT;
            default: i_valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle MIPS control unit (Moore FSM, Mealy only on
// IRWrite/PC_en/next-state). Drives the shared-memory, single-ALU datapath.
//   Inputs : clk, rst_n (async active-low), OPcode/Fun (IR fields),
//            zero (ALU flag), MIO_ready (bus access complete)
//   Outputs: datapath strobes and mux selects, trap (in TRAP), state (debug)
//   Params : WAIT_MIO (honour MIO_ready), MEM_TIMEOUT (0 = off), CNT_W
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int WAIT_MIO    = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       PC_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       CPU_MIO,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_Control,
    output logic [1:0] PCSource,
    output logic       trap,
    output logic [4:0] state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             ready_s;
    logic             in_mem_s;
    logic             timeout_s;
    logic [2:0]       r_alu_s, i_alu_s;
    logic             r_valid_s, i_valid_s;

    mcpu_alu_dec u_alu_dec (
        .OPcode     (OPcode),
        .Fun        (Fun),
        .r_alu_ctrl (r_alu_s),
        .r_valid    (r_valid_s),
        .i_alu_ctrl (i_alu_s),
        .i_valid    (i_valid_s)
    );

    assign ready_s  = (WAIT_MIO != 0) ? MIO_ready : 1'b1;
    assign in_mem_s = is_mem_state(state_q);
    // A ready arriving on the limit cycle still completes the access.
    assign timeout_s = (MEM_TIMEOUT != 0) && in_mem_s && !ready_s &&
                       (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
    assign state = state_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (timeout_s)    state_d = S_TRAP;
                else if (ready_s) state_d = S_ID;
                else              state_d = S_IF;
            end
            S_ID: begin
                case (OPcode)
                    OP_RTYPE: begin
                        if (Fun == FN_JR)        state_d = S_JR;
                        else if (Fun == FN_JALR) state_d = S_JALR;
                        else if (r_valid_s)      state_d = S_REX;
                        else                     state_d = S_TRAP;
                    end
                    OP_LW, OP_SW: state_d = S_MA;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_J:         state_d = S_J;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        if (i_valid_s) state_d = S_IEX;
                        else           state_d = S_TRAP;
                    end
                endcase
            end
            S_REX: state_d = S_RWB;
            S_IEX: state_d = S_IWB;
            S_MA: begin
                if (OPcode == OP_SW) state_d = S_MW;
                else                 state_d = S_MR;
            end
            S_MR: begin
                if (timeout_s)    state_d = S_TRAP;
                else if (ready_s) state_d = S_LWB;
                else              state_d = S_MR;
            end
            S_MW: begin
                if (timeout_s)    state_d = S_TRAP;
                else if (ready_s) state_d = S_IF;
                else              state_d = S_MW;
            end
            S_RWB, S_IWB, S_LWB, S_BEQ, S_BNE,
            S_J, S_JR, S_JAL, S_JALR, S_LUI: state_d = S_IF;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Wait counter: zero on any state change or ready, counts stalled cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_mem_s && !ready_s) begin
            // Saturate so a disabled timeout never wraps into a false match.
            if (wait_cnt_q != {CNT_W{1'b1}}) wait_cnt_d = wait_cnt_q + CNT_W'(1);
            else                             wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = '0;
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Output decode from current state
    always_comb begin
        PC_en       = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        CPU_MIO     = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_ALU;
        RegWrite    = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        ALU_Control = ALU_ADD;
        PCSource    = PCS_ALU;
        trap        = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (ready_s) begin
                    IRWrite = 1'b1;
                    PC_en   = 1'b1;
                end else begin
                    IRWrite = 1'b0;
                    PC_en   = 1'b0;
                end
            end
            S_ID: ALUSrcB = SRCB_BOFS;
            S_REX: begin
                ALUSrcA     = (Fun == FN_SRL) ? SRCA_SHAMT : SRCA_A;
                ALUSrcB     = SRCB_B;
                ALU_Control = r_alu_s;
            end
            S_RWB, S_IWB: begin
                RegDst   = (state_q == S_RWB) ? RD_RD : RD_RT;
                RegWrite = 1'b1;
            end
            S_IEX: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = i_alu_s;
            end
            S_MA: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MR: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
            end
            S_MW: begin
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
                IorD     = 1'b1;
            end
            S_LWB: begin
                MemtoReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA     = SRCA_A;
                ALU_Control = ALU_SUB;
                PCSource    = PCS_ALUOUT;
                PC_en       = (state_q == S_BEQ) ? zero : ~zero;
            end
            S_J: begin
                PC_en    = 1'b1;
                PCSource = PCS_JUMP;
            end
            S_JR: begin
                PC_en    = 1'b1;
                PCSource = PCS_REG;
            end
            S_JAL: begin
                PC_en    = 1'b1;
                PCSource = PCS_JUMP;
                RegWrite = 1'b1;
                RegDst   = RD_RA;
                MemtoReg = M2R_PC;
            end
            S_JALR: begin
                PC_en    = 1'b1;
                PCSource = PCS_REG;
                RegWrite = 1'b1;
                RegDst   = RD_RD;
                MemtoReg = M2R_PC;
            end
            S_LUI: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_LUI;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mcpu_ctrl.sv
module tb_mcpu_ctrl;
    import mcpu_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OPcode = 6'd0;
    logic [5:0] Fun = 6'd0;
    logic       zero = 1'b0;
    logic       MIO_ready = 1'b0;
    logic       PC_en, IorD, MemRead, MemWrite, IRWrite, CPU_MIO, RegWrite, trap;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [2:0] ALU_Control;
    logic [4:0] state;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       cpu_mio;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] pc_src;
        logic       trap;
    } ctl_t;

    ctl_t obs_s;
    int   vectors = 0;
    int   fails   = 0;

    mcpu_ctrl #(.WAIT_MIO(1), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero),
        .MIO_ready(MIO_ready), .PC_en(PC_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .CPU_MIO(CPU_MIO), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_Control(ALU_Control), .PCSource(PCSource), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    assign obs_s = {PC_en, IorD, MemRead, MemWrite, IRWrite, CPU_MIO, RegDst, MemtoReg,
                    RegWrite, ALUSrcA, ALUSrcB, ALU_Control, PCSource, trap};

    // ---------------- reference model: expected control words ----------------
    function automatic ctl_t c_idle();
        ctl_t c;
        c = '0;
        c.alu = 3'b010;
        return c;
    endfunction

    function automatic ctl_t c_fetch(input logic rdy);
        ctl_t c;
        c = c_idle();
        c.mem_read = 1'b1; c.cpu_mio = 1'b1; c.src_b = 2'b01;
        c.ir_write = rdy;  c.pc_en = rdy;
        return c;
    endfunction

    function automatic ctl_t c_decode();
        ctl_t c;
        c = c_idle();
        c.src_b = 2'b11;
        return c;
    endfunction

    function automatic ctl_t c_trap();
        ctl_t c;
        c = c_idle();
        c.trap = 1'b1;
        return c;
    endfunction

    // {valid, alu code} for an R-type funct
    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b1_010;
            6'h22:   return 4'b1_110;
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h26:   return 4'b1_011;
            6'h27:   return 4'b1_100;
            6'h2a:   return 4'b1_111;
            6'h02:   return 4'b1_101;
            default: return 4'b0_000;
        endcase
    endfunction

    // {valid, alu code} for an immediate opcode
    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 4'b1_010;
            6'h0c:   return 4'b1_000;
            6'h0d:   return 4'b1_001;
            6'h0e:   return 4'b1_011;
            6'h0a:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- checks ----------------
    task automatic chk_ctl(input ctl_t exp, input string tag);
        vectors++;
        assert (obs_s === exp) else begin
            fails++;
            $error("FAIL %s: controls got %06h required %06h (state %0d)", tag, obs_s, exp, state);
        end
    endtask

    task automatic chk_state(input logic [4:0] exp, input string tag);
        vectors++;
        assert (state === exp) else begin
            fails++;
            $error("FAIL %s: state got %0d required %0d", tag, state, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check just after, advance.
    task automatic step(input ctl_t exp, input logic rdy, input logic z, input string tag);
        MIO_ready = rdy;
        zero      = z;
        #1;
        chk_ctl(exp, tag);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        MIO_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_ctl(c_fetch(1'b0), "reset_ctl");
        chk_state(S_IF, "reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic trap_then_reset();
        chk_state(S_TRAP, "trap_state");
        for (int i = 0; i < 3; i++) step(c_trap(), rbit(), rbit(), "trap_hold");
        chk_state(S_TRAP, "trap_held");
        reset_pulse();
    endtask

    // Execute one instruction against the phase sequence derived from its class.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int if_wait, input int mem_wait);
        ctl_t       c;
        logic [3:0] ra, ia;
        OPcode = op;
        Fun    = fn;
        ra     = r_alu(fn);
        ia     = i_alu(op);
        chk_state(S_IF, "instr_start");
        for (int i = 0; i < if_wait; i++) step(c_fetch(1'b0), 1'b0, rbit(), "if_wait");
        step(c_fetch(1'b1), 1'b1, rbit(), "if_ready");
        step(c_decode(), rbit(), rbit(), "id");
        c = c_idle();
        if (op == 6'h00 && fn == 6'h08) begin
            c.pc_en = 1'b1; c.pc_src = 2'b11;
            step(c, rbit(), rbit(), "jr");
        end else if (op == 6'h00 && fn == 6'h09) begin
            c.pc_en = 1'b1; c.pc_src = 2'b11; c.reg_write = 1'b1;
            c.reg_dst = 2'b01; c.mem_to_reg = 2'b11;
            step(c, rbit(), rbit(), "jalr");
        end else if (op == 6'h00 && ra[3]) begin
            c.src_a = (fn == 6'h02) ? 2'b10 : 2'b01;
            c.src_b = 2'b00; c.alu = ra[2:0];
            step(c, rbit(), rbit(), "rex");
            c = c_idle();
            c.reg_dst = 2'b01; c.reg_write = 1'b1;
            step(c, rbit(), rbit(), "rwb");
        end else if (op == 6'h23 || op == 6'h2b) begin
            c.src_a = 2'b01; c.src_b = 2'b10;
            step(c, rbit(), rbit(), "ma");
            c = c_idle();
            c.cpu_mio = 1'b1; c.iord = 1'b1;
            if (op == 6'h23) c.mem_read = 1'b1;
            else             c.mem_write = 1'b1;
            for (int i = 0; i < mem_wait; i++) step(c, 1'b0, rbit(), "mem_wait");
            step(c, 1'b1, rbit(), "mem_ready");
            if (op == 6'h23) begin
                c = c_idle();
                c.mem_to_reg = 2'b01; c.reg_write = 1'b1;
                step(c, rbit(), rbit(), "lwb");
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c.src_a = 2'b01; c.alu = 3'b110; c.pc_src = 2'b01;
            c.pc_en = (op == 6'h04) ? z : ~z;
            step(c, rbit(), z, "branch");
        end else if (op == 6'h02 || op == 6'h03) begin
            c.pc_en = 1'b1; c.pc_src = 2'b10;
            if (op == 6'h03) begin
                c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b11;
            end
            step(c, rbit(), rbit(), "jump");
        end else if (op == 6'h0f) begin
            c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
            step(c, rbit(), rbit(), "lui");
        end else if (ia[3]) begin
            c.src_a = 2'b01; c.src_b = 2'b10; c.alu = ia[2:0];
            step(c, rbit(), rbit(), "iex");
            c = c_idle();
            c.reg_write = 1'b1;
            step(c, rbit(), rbit(), "iwb");
        end else begin
            trap_then_reset();
        end
    endtask

    logic [5:0] op_tab [14] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                6'h03, 6'h0f, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a};
    logic [5:0] fn_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                6'h02, 6'h08, 6'h09};

    initial begin
        ctl_t       c;
        logic [5:0] op, fn;

        // Reset state, held for a few cycles
        #1;
        chk_ctl(c_fetch(1'b0), "por_ctl");
        chk_state(S_IF, "por_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 wait cycles in MR
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
        run_instr(6'h00, 6'h02, 1'b0, 0, 0);   // srl uses shamt
        run_instr(6'h2b, 6'h00, 1'b0, TMO, TMO); // ready on the limit cycle wins
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'h00, 6'h3f, 1'b0, 0, 0);   // illegal funct

        // Fetch timeout: TMO stalled cycles tolerated, the next one traps
        OPcode = 6'h00; Fun = 6'h20;
        for (int i = 0; i <= TMO; i++) step(c_fetch(1'b0), 1'b0, 1'b0, "if_tmo_wait");
        trap_then_reset();

        // Load timeout in MR
        OPcode = 6'h23;
        step(c_fetch(1'b1), 1'b1, 1'b0, "mr_tmo_if");
        step(c_decode(), 1'b0, 1'b0, "mr_tmo_id");
        c = c_idle(); c.src_a = 2'b01; c.src_b = 2'b10;
        step(c, 1'b0, 1'b0, "mr_tmo_ma");
        c = c_idle(); c.cpu_mio = 1'b1; c.iord = 1'b1; c.mem_read = 1'b1;
        for (int i = 0; i <= TMO; i++) step(c, 1'b0, 1'b0, "mr_tmo_wait");
        trap_then_reset();

        // Async reset in the middle of a store
        OPcode = 6'h2b;
        step(c_fetch(1'b1), 1'b1, 1'b0, "mwrst_if");
        step(c_decode(), 1'b0, 1'b0, "mwrst_id");
        c = c_idle(); c.src_a = 2'b01; c.src_b = 2'b10;
        step(c, 1'b0, 1'b0, "mwrst_ma");
        c = c_idle(); c.cpu_mio = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1;
        step(c, 1'b0, 1'b0, "mwrst_mw");
        #1;
        chk_ctl(c, "mwrst_mw_hold");
        rst_n = 1'b0;
        #1;
        chk_ctl(c_fetch(1'b0), "mwrst_drop");
        chk_state(S_IF, "mwrst_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else                           op = op_tab[$urandom_range(0, 13)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            else                           fn = fn_tab[$urandom_range(0, 9)];
            run_instr(op, fn, rbit(), $urandom_range(0, TMO), $urandom_range(0, TMO));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
